// File: rtl/ingress_requester.sv
// Ingress requester: buffers packet words in a FIFO, presents the header's
// destination mask to the arbiter, streams payload beats on grant, discards bad packets.
module ingress_requester #(
  parameter int dst_size   = 4,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int STARVE_LIM = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic [dst_size-1:0] port_dst,
  input  logic                grant,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic [7:0]          drop_cnt,
  output logic                starve
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

  word_t               mem [DEPTH];
  word_t               head;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                full, empty, push, pop, drop_inc;
  logic [dst_size-1:0] hdr_mask, dst_reg, dst_nx;
  state_t              state, state_nx;
  logic [15:0]         starve_cnt;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign hdr_mask = head.data[dst_size-1:0];

  // Storage carries no reset; reads are only observed through valid-qualified paths.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= word_t'({in_last, in_data});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dst_reg <= '0;
    end else begin
      state   <= state_nx;
      dst_reg <= dst_nx;
    end
  end

  // Requests only go out while a payload word sits at the head, so grant is a per-beat ready.
  always_comb begin
    state_nx  = state;
    dst_nx    = dst_reg;
    pop       = 1'b0;
    drop_inc  = 1'b0;
    port_dst  = '0;
    out_valid = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        if (hdr_mask == '0 || head.last) drop_inc = 1'b1;
        if (!head.last) begin
          if (hdr_mask == '0) state_nx = DROP;
          else begin
            dst_nx   = hdr_mask;
            state_nx = SEND;
          end
        end
      end
      SEND: if (!empty) begin
        port_dst = dst_reg;
        if (grant) begin
          out_valid = 1'b1;
          pop       = 1'b1;
          if (head.last) begin
            state_nx = IDLE;
            dst_nx   = '0;
          end
        end
      end
      DROP: if (!empty) begin
        pop = 1'b1;
        if (head.last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_data = out_valid ? head.data : '0;
  assign out_last = out_valid && head.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (port_dst != '0 && !grant) begin
        if (starve_cnt != 16'hFFFF) starve_cnt <= starve_cnt + 16'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign starve = (starve_cnt >= 16'(STARVE_LIM));

endmodule

// File: tb/tb_ingress_requester.sv
// Bench for ingress_requester: packet-level queue model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ingress_requester;
  localparam int DW    = 32;
  localparam int NDST  = 4;
  localparam int DEPTH = 16;
  localparam int SLIM  = 64;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            in_valid = 1'b0, in_last = 1'b0, grant = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready, out_valid, out_last, starve;
  logic [NDST-1:0] port_dst;
  logic [DW-1:0]   out_data;
  logic [7:0]      drop_cnt;

  int vectors = 0, miscompares = 0;

  ingress_requester #(.dst_size(NDST), .DATA_W(DW), .DEPTH(DEPTH), .STARVE_LIM(SLIM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .port_dst(port_dst), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .drop_cnt(drop_cnt), .starve(starve)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Packet-level model: words waiting in the buffer, plus what the current packet is doing.
  logic [DW:0]     q[$];
  bit              sending, discarding;
  logic [NDST-1:0] m_dst;
  int              m_drops, m_wait;

  logic [DW:0]     beats[$];
  logic [DW:0]     exp_b[$];
  logic [NDST-1:0] pd_watch = '0, pd_or = '0;
  int              pd_hits = 0;

  always @(negedge clk) begin
    logic [NDST-1:0] e_pd;
    logic [DW:0]     hd;
    logic            e_ov, e_rdy, take;
    if (!rst_n) begin
      chk("reset in_ready", in_ready, 1);
      chk("reset port_dst", port_dst, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_last", out_last, 0);
      chk("reset drop_cnt", drop_cnt, 0);
      chk("reset starve", starve, 0);
      q.delete();
      sending = 0; discarding = 0; m_dst = '0; m_drops = 0; m_wait = 0;
    end else begin
      hd    = (q.size() > 0) ? q[0] : '0;
      e_rdy = q.size() < DEPTH;
      e_pd  = (sending && q.size() > 0) ? m_dst : '0;
      e_ov  = (e_pd != '0) && grant;
      chk("in_ready", in_ready, e_rdy);
      chk("port_dst", port_dst, e_pd);
      chk("out_valid", out_valid, e_ov);
      chk("out_data", out_data, e_ov ? hd[DW-1:0] : '0);
      chk("out_last", out_last, e_ov & hd[DW]);
      chk("drop_cnt", drop_cnt, m_drops);
      chk("starve", starve, m_wait >= SLIM);
      if (out_valid) beats.push_back({out_last, out_data});
      if (port_dst == pd_watch) pd_hits++;
      pd_or |= port_dst;
      take = 0;
      if (q.size() > 0) begin
        if (sending) begin
          if (grant) begin take = 1; if (hd[DW]) sending = 0; end
        end else if (discarding) begin
          take = 1;
          if (hd[DW]) discarding = 0;
        end else begin
          take = 1;
          if (hd[NDST-1:0] == '0 || hd[DW]) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
          if (!hd[DW]) begin
            if (hd[NDST-1:0] == '0) discarding = 1;
            else begin sending = 1; m_dst = hd[NDST-1:0]; end
          end
        end
      end
      m_wait = (e_pd != '0 && !grant) ? ((m_wait < 65535) ? m_wait + 1 : 65535) : 0;
      if (take) void'(q.pop_front());
      if (in_valid && e_rdy) q.push_back({in_last, in_data});
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL push timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
  endtask

  task automatic chk_beats(string nm);
    chk({nm, " beat count"}, beats.size(), exp_b.size());
    for (int i = 0; i < beats.size() && i < exp_b.size(); i++)
      chk($sformatf("%s beat%0d", nm, i), beats[i], exp_b[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int idx, first, rise;
    logic s75, s76;
    step(3);
    rst_n = 1'b1;

    // Header 0x5 + 3 payload words, grant tied high; first push right after release.
    grant = 1; beats.delete(); pd_watch = 4'h5; pd_hits = 0;
    push(32'h5, 0); push(32'hA1, 0); push(32'hA2, 0); push(32'hA3, 1);
    step(4);
    chk("t1 request cycles", pd_hits, 3);
    exp_b.delete();
    exp_b.push_back({1'b0, 32'hA1}); exp_b.push_back({1'b0, 32'hA2}); exp_b.push_back({1'b1, 32'hA3});
    chk_beats("t1");

    // Same packet, grant pattern 1,0,0,1,1.
    grant = 0;
    push(32'h5, 0); push(32'hB1, 0); push(32'hB2, 0); push(32'hB3, 1);
    beats.delete(); pd_hits = 0;
    grant = 1; step(1); grant = 0; step(2); grant = 1; step(2);
    grant = 0; step(3);
    chk("t2 request cycles", pd_hits, 5);
    exp_b.delete();
    exp_b.push_back({1'b0, 32'hB1}); exp_b.push_back({1'b0, 32'hB2}); exp_b.push_back({1'b1, 32'hB3});
    chk_beats("t2");

    // Zero-mask packet is discarded, the following one is sent.
    grant = 1; beats.delete(); pd_or = '0;
    push(32'h0, 0); push(32'hD1, 0); push(32'hD2, 1); push(32'h2, 0); push(32'hE1, 1);
    step(4);
    chk("t3 drop_cnt", drop_cnt, 1);
    chk("t3 masks seen", pd_or, 4'h2);
    exp_b.delete(); exp_b.push_back({1'b1, 32'hE1});
    chk_beats("t3");

    // Fill with grant low, then drain.
    grant = 0;
    push(32'h1, 0);
    beats.delete(); idx = 0;
    for (int c = 0; c < 60; c++) begin
      grant = (c >= 25);
      in_valid = (idx < 20); in_data = 32'h100 + idx; in_last = (idx == 19);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (c == 24) begin
        chk("t4 accepted while stalled", idx, 16);
        chk("t4 in_ready when full", in_ready, 0);
      end
      if (c == 25) chk("t4 in_ready full during pop", in_ready, 0);
      if (c == 26) chk("t4 in_ready reasserted", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0; in_data = '0; grant = 0;
    exp_b.delete();
    for (int i = 0; i < 20; i++) exp_b.push_back({i == 19, 32'h100 + i});
    chk_beats("t4");

    // Starvation: request held ungranted.
    first = -1; rise = -1; s75 = 0; s76 = 1;
    for (int c = 0; c < 80; c++) begin
      in_valid = (c < 2); in_data = (c == 0) ? 32'h3 : 32'hBEEF; in_last = (c == 1);
      grant = (c == 75);
      @(negedge clk);
      if (port_dst != '0 && first < 0) first = c;
      if (starve && rise < 0) rise = c;
      if (c == 75) s75 = starve;
      if (c == 76) s76 = starve;
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0; in_data = '0; grant = 0;
    chk("t5 request start", first, 2);
    chk("t5 starve after waiting", rise - first, SLIM);
    chk("t5 starve on grant cycle", s75, 1);
    chk("t5 starve after grant", s76, 0);

    // Drop counter saturation with header-only packets.
    for (int i = 0; i < 260; i++) begin
      in_valid = 1; in_data = i; in_last = 1;
      step(1);
    end
    in_valid = 0; in_last = 0; in_data = '0;
    step(3);
    chk("t7 drop_cnt saturated", drop_cnt, 255);

    // Reset mid-packet after 2 of 4 beats.
    push(32'h4, 0); push(32'hC1, 0); push(32'hC2, 0); push(32'hC3, 0); push(32'hC4, 1);
    grant = 1; beats.delete();
    step(2);
    chk("t6 beats before reset", beats.size(), 2);
    rst_n = 0;
    #1;
    chk("t6 port_dst in reset", port_dst, 0);
    chk("t6 out_valid in reset", out_valid, 0);
    chk("t6 out_data in reset", out_data, 0);
    chk("t6 out_last in reset", out_last, 0);
    chk("t6 drop_cnt in reset", drop_cnt, 0);
    chk("t6 starve in reset", starve, 0);
    grant = 0;
    step(2);
    beats.delete();
    rst_n = 1;
    push(32'h8, 0); push(32'hF1, 0); push(32'hF2, 1);
    grant = 1;
    step(4);
    exp_b.delete(); exp_b.push_back({1'b0, 32'hF1}); exp_b.push_back({1'b1, 32'hF2});
    chk_beats("t6");
    chk("t6 drop_cnt after reset", drop_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
